fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Fetch-stage next-PC generator that sits directly upstream of the branch target buffer. It owns the fetch PC register and drives pc_fetch to the BTB and instruction memory. It combines the BTB's combinational target with an internal bimodal predictor (2-bit saturating counters plus valid bits) to choose the next PC. It also accepts branch resolutions from execute, trains the predictor, drives the BTB update port, and redirects fetch on mispredict.

Parameters:
SIZE, 11, log2 of predictor/BTB entry count; index = PC[SIZE+1:2]; must match the BTB size
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
stall  input  1  hold pc_fetch this cycle (imem/hazard stall)
pc_fetch  output  32  current fetch PC; to BTB pc_fetch and imem
bt_fetch  input  32  BTB target for pc_fetch (combinational from BTB)
pred_taken  output  1  prediction for the instruction at pc_fetch
pred_target  output  32  predicted next PC for pc_fetch
res_valid  input  1  conditional branch/jump resolved this cycle
res_pc  input  32  PC of the resolved instruction
res_taken  input  1  actual direction
res_target  input  32  actual taken target
res_mispredict  input  1  execute detected a wrong next-PC; qualified by res_valid
flush  output  1  redirect in progress; younger fetched instructions are killed
btb_enable_res  output  1  BTB write enable
btb_pc_res  output  32  BTB write index PC
btb_bt_res  output  32  BTB write data

Behaviour:
- Reset: asynchronous on nRST low.
  - pc_fetch = RESET_PC.
  - All 2^SIZE counters = 2'b01 (weakly not-taken).
  - All valid bits = 0.
  - flush = 0.
  - pred_taken = 0 and pred_target = RESET_PC+4 while pc_fetch = RESET_PC.
- Index: idx(p) = p[SIZE+1:2]. The low 2 bits of the PC are ignored.
- Prediction (combinational from pc_fetch):
  - pred_taken = valid[idx] & counter[idx][1].
  - pred_target = pred_taken ? bt_fetch : pc_fetch+4. The addition is 32-bit and wraps modulo 2^32.
- Next-PC priority, registered on posedge CLK:
  1. res_valid & res_mispredict: pc_fetch <= res_taken ? res_target : res_pc+4. This overrides stall.
  2. stall: pc_fetch holds.
  3. Otherwise: pc_fetch <= pred_target.
- flush = res_valid & res_mispredict, combinational, same cycle as the redirect. The first correct-path PC appears on pc_fetch the following cycle, so the redirect penalty is 1 cycle.
- Training on res_valid, updated at the next posedge:
  - valid[idx(res_pc)] <= 1.
  - If res_taken: counter saturating-increments, 11 stays 11.
  - If not taken: counter saturating-decrements, 00 stays 00.
  - Training occurs regardless of res_mispredict and regardless of stall.
- BTB update (combinational pass-through):
  - btb_enable_res = res_valid & res_taken.
  - btb_pc_res = res_pc.
  - btb_bt_res = res_target.
  - Not-taken resolutions never write the BTB.
- Same-index read/write collision: the prediction in the cycle of the write uses the old counter/valid value. The new value is visible from the next cycle. No bypass.
- Aliasing: PCs sharing idx share an entry. No tags; this is accepted behaviour.
- res_mispredict without res_valid is ignored.
- Reset asserted mid-operation discards any pending redirect and all training state.

Test Plan:
- Reset with RESET_PC=0x200, stall=0, no res -> pc_fetch sequence 0x200, 0x204, 0x208; pred_taken=0; flush=0.
- res_valid=1, res_pc=0x210, res_taken=1, res_target=0x400, res_mispredict=1 while pc_fetch=0x214 -> flush=1 that cycle; btb_enable_res=1, btb_pc_res=0x210, btb_bt_res=0x400; next pc_fetch=0x400; counter[idx(0x210)]=2'b10 and valid=1.
- Loop with BTB model returning 0x400 for 0x210: after the training above, fetch reaching 0x210 -> pred_taken=1, pred_target=0x400, next pc_fetch=0x400.
- Counter saturation: three taken resolutions on 0x300 -> counter=11. Then one not-taken -> 10, still predicts taken. A second not-taken -> 01, pred_taken=0 and pred_target=0x304.
- stall=1 held 3 cycles with simultaneous mispredict redirect (res_taken=0, res_pc=0x500) in cycle 2 -> pc_fetch holds cycle 1, becomes 0x504 after cycle 2, holds after cycle 3.
- Collision and wrap: pc_fetch=0x210 with simultaneous training of 0x210 from 01 to 10 -> pred_taken=0 that cycle, 1 the next cycle. Separately, pc_fetch=0xFFFF_FFFC unpredicted -> next pc_fetch=0x0000_0000. Reset asserted mid-redirect -> pc_fetch=RESET_PC and all valid=0.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Bundle of the fetch, branch-resolution and BTB-update signals
//               of the fetch-stage next-PC generator. The slave modport is
//               the PC unit; the master modport is its environment (imem,
//               BTB, execute stage).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;
  // fetch side
  logic        stall;
  logic [31:0] pc_fetch;
  logic [31:0] bt_fetch;
  logic        pred_taken;
  logic [31:0] pred_target;
  // resolution from execute
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_mispredict;
  logic        flush;
  // BTB write port
  logic        btb_enable_res;
  logic [31:0] btb_pc_res;
  logic [31:0] btb_bt_res;

  modport slave (
    input  stall, bt_fetch, res_valid, res_pc, res_taken, res_target,
           res_mispredict,
    output pc_fetch, pred_taken, pred_target, flush, btb_enable_res,
           btb_pc_res, btb_bt_res
  );

  modport master (
    output stall, bt_fetch, res_valid, res_pc, res_taken, res_target,
           res_mispredict,
    input  pc_fetch, pred_taken, pred_target, flush, btb_enable_res,
           btb_pc_res, btb_bt_res
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch-stage next-PC generator. Owns the fetch PC, predicts
//               with a bimodal table (2-bit counters + valid bits) combined
//               with the BTB target, trains on branch resolutions, forwards
//               taken resolutions to the BTB and redirects on mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
  parameter int          SIZE     = 11,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           CLK,
  input  logic           nRST,
  fetch_pc_unit_if.slave bus
);

  localparam int c_DEPTH = 1 << SIZE;

  logic [31:0]        r_pc;
  logic [1:0]         r_cnt [c_DEPTH];
  logic [c_DEPTH-1:0] r_valid;

  logic [SIZE-1:0]    w_fetch_idx;
  logic [SIZE-1:0]    w_res_idx;
  logic               w_pred_taken;
  logic [31:0]        w_pred_target;
  logic               w_redirect;
  logic [31:0]        w_redirect_pc;
  logic [31:0]        w_next_pc;

  // Table index ignores the byte offset bits of the PC; no tags, so aliases
  // share an entry.
  assign w_fetch_idx = r_pc[SIZE+1:2];
  assign w_res_idx   = bus.res_pc[SIZE+1:2];

  // Prediction reads the registered table, so a same-cycle write is not seen.
  always_comb begin
    w_pred_taken  = r_valid[w_fetch_idx] & r_cnt[w_fetch_idx][1];
    w_pred_target = w_pred_taken ? bus.bt_fetch : (r_pc + 32'd4);
  end

  // Next-PC select: redirect beats stall, stall beats prediction.
  always_comb begin
    w_redirect    = bus.res_valid & bus.res_mispredict;
    w_redirect_pc = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
    if (w_redirect)
      w_next_pc = w_redirect_pc;
    else if (bus.stall)
      w_next_pc = r_pc;
    else
      w_next_pc = w_pred_target;
  end

  // Fetch PC register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_pc <= RESET_PC;
    else
      r_pc <= w_next_pc;
  end

  // Predictor training: every resolution marks the entry valid and nudges its
  // saturating counter toward the actual direction, independent of stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < c_DEPTH; i++)
        r_cnt[i] <= 2'b01;
      r_valid <= '0;
    end else if (bus.res_valid) begin
      r_valid[w_res_idx] <= 1'b1;
      if (bus.res_taken) begin
        if (r_cnt[w_res_idx] != 2'b11)
          r_cnt[w_res_idx] <= r_cnt[w_res_idx] + 2'b01;
      end else begin
        if (r_cnt[w_res_idx] != 2'b00)
          r_cnt[w_res_idx] <= r_cnt[w_res_idx] - 2'b01;
      end
    end
  end

  assign bus.pc_fetch       = r_pc;
  assign bus.pred_taken     = w_pred_taken;
  assign bus.pred_target    = w_pred_target;
  assign bus.flush          = w_redirect;
  // Only taken resolutions carry a target worth caching in the BTB.
  assign bus.btb_enable_res = bus.res_valid & bus.res_taken;
  assign bus.btb_pc_res     = bus.res_pc;
  assign bus.btb_bt_res     = bus.res_target;

endmodule
`default_nettype wire
